trace_serializer: RTL and testbench

TRACE_SERIALIZER -- requirements
Module: trace_serializer

---
 rtl/swerv_types.sv | 25 ++
 rtl/trace_serializer.sv | 162 ++++++++++++++++
 tb/tb_trace_serializer.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/swerv_types.sv
// Shared SweRV trace types: the per-cycle retire packet and the
// single-instruction record emitted by the trace serializer.
package swerv_types;

    typedef struct packed {
        logic [2:0]  trace_rv_i_valid_ip;
        logic [95:0] trace_rv_i_insn_ip;
        logic [95:0] trace_rv_i_address_ip;
        logic [2:0]  trace_rv_i_exception_ip;
        logic [4:0]  trace_rv_i_ecause_ip;
        logic [2:0]  trace_rv_i_interrupt_ip;
        logic [31:0] trace_rv_i_tval_ip;
    } trace_pkt_t;

    typedef struct packed {
        logic [1:0]  slot;
        logic [31:0] insn;
        logic [31:0] addr;
        logic        exception;
        logic [4:0]  ecause;
        logic        interrupt;
        logic [31:0] tval;
    } trace_rec_t;

endpackage

// File: rtl/trace_serializer.sv
// Buffers up to DEPTH retire packets and serializes each one into one
// record per valid slot over a valid/ready stream. Packets arriving while
// the buffer is full are dropped and counted.
module trace_serializer
    import swerv_types::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_l,
    input  trace_pkt_t  trace_pkt,
    input  logic        trc_clear,
    output logic        trc_valid,
    input  logic        trc_ready,
    output trace_rec_t  trc_rec,
    output logic        trc_overflow,
    output logic [15:0] trc_drop_cnt
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    // Slot walk within the head entry; the state names the lowest pending slot.
    typedef enum logic [1:0] {
        SLOT0 = 2'd0,
        SLOT1 = 2'd1,
        SLOT2 = 2'd2
    } slot_e;

    trace_pkt_t       mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    slot_e            slot_q;
    logic             ovf_q;
    logic [15:0]      drop_q;

    trace_pkt_t       head;
    logic [2:0]       hv;
    logic             present;
    logic             full;
    logic             push;
    logic             drop;
    logic             xfer;
    logic             pop;
    logic [1:0]       cur_slot;
    logic             last_slot;
    slot_e            next_slot;
    logic [6:0]       bit_off;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign head      = mem_q[rd_ptr_q];
    assign hv        = head.trace_rv_i_valid_ip;
    assign present   = |trace_pkt.trace_rv_i_valid_ip;
    assign full      = (count_q == CNT_W'(DEPTH));
    assign push      = present && !full && !trc_clear;
    assign drop      = present && full && !trc_clear;
    assign trc_valid = (count_q != '0);
    assign xfer      = trc_valid && trc_ready;
    assign pop       = xfer && last_slot;

    // Resolve the slot presented now, whether it is the entry's last, and the one after it.
    always_comb begin
        cur_slot  = 2'd0;
        last_slot = 1'b1;
        next_slot = SLOT0;
        case (slot_q)
            SLOT0:   cur_slot = hv[0] ? 2'd0 : (hv[1] ? 2'd1 : 2'd2);
            SLOT1:   cur_slot = hv[1] ? 2'd1 : 2'd2;
            default: cur_slot = 2'd2;
        endcase
        case (cur_slot)
            2'd0: begin
                last_slot = !(hv[1] || hv[2]);
                next_slot = hv[1] ? SLOT1 : SLOT2;
            end
            2'd1: begin
                last_slot = !hv[2];
                next_slot = SLOT2;
            end
            default: begin
                last_slot = 1'b1;
                next_slot = SLOT0;
            end
        endcase
    end

    // Build the outgoing record from the head entry; forced to zero while empty.
    always_comb begin
        bit_off = {cur_slot, 5'b0};
        trc_rec = '0;
        if (trc_valid) begin
            trc_rec.slot      = cur_slot;
            trc_rec.insn      = head.trace_rv_i_insn_ip[bit_off +: 32];
            trc_rec.addr      = head.trace_rv_i_address_ip[bit_off +: 32];
            trc_rec.exception = head.trace_rv_i_exception_ip[cur_slot];
            trc_rec.ecause    = head.trace_rv_i_ecause_ip;
            trc_rec.interrupt = head.trace_rv_i_interrupt_ip[cur_slot];
            trc_rec.tval      = head.trace_rv_i_tval_ip;
        end
    end

    // Occupancy follows push/pop; push is decided on the registered count.
    always_comb begin
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Packet storage carries no reset; validity is tracked by the control state.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= trace_pkt;
        end
    end

    // Control state: pointers, occupancy, slot walk and drop accounting.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            slot_q   <= SLOT0;
            ovf_q    <= 1'b0;
            drop_q   <= '0;
        end else if (trc_clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            slot_q   <= SLOT0;
            ovf_q    <= 1'b0;
            drop_q   <= '0;
        end else begin
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (drop) begin
                ovf_q  <= 1'b1;
                drop_q <= sat_inc16(drop_q);
            end
            if (xfer) begin
                if (last_slot) begin
                    rd_ptr_q <= rd_ptr_q + AW'(1);
                    slot_q   <= SLOT0;
                end else begin
                    slot_q   <= next_slot;
                end
            end
        end
    end

    assign trc_overflow = ovf_q;
    assign trc_drop_cnt = drop_q;

endmodule

// File: tb/tb_trace_serializer.sv
// Testbench for trace_serializer: directed scenarios plus random traffic,
// compared every cycle against a packet-queue reference model.
module tb_trace_serializer;
    import swerv_types::*;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_l;
    trace_pkt_t  trace_pkt;
    logic        trc_clear;
    logic        trc_valid;
    logic        trc_ready;
    trace_rec_t  trc_rec;
    logic        trc_overflow;
    logic [15:0] trc_drop_cnt;

    int checks;
    int errors;

    // Reference model state
    trace_pkt_t  m_q[$];
    int          m_idx;
    logic        m_ovf;
    logic [15:0] m_drop;

    trace_serializer #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_l        (rst_l),
        .trace_pkt    (trace_pkt),
        .trc_clear    (trc_clear),
        .trc_valid    (trc_valid),
        .trc_ready    (trc_ready),
        .trc_rec      (trc_rec),
        .trc_overflow (trc_overflow),
        .trc_drop_cnt (trc_drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic int nrec(input trace_pkt_t p);
        int n = 0;
        for (int i = 0; i < 3; i++) if (p.trace_rv_i_valid_ip[i]) n++;
        return n;
    endfunction

    // k-th record (in ascending slot order) of packet p
    function automatic trace_rec_t get_rec(input trace_pkt_t p, input int k);
        trace_rec_t r = '0;
        int n = 0;
        for (int i = 0; i < 3; i++) begin
            if (p.trace_rv_i_valid_ip[i]) begin
                if (n == k) begin
                    r.slot      = 2'(i);
                    r.insn      = p.trace_rv_i_insn_ip[32*i +: 32];
                    r.addr      = p.trace_rv_i_address_ip[32*i +: 32];
                    r.exception = p.trace_rv_i_exception_ip[i];
                    r.ecause    = p.trace_rv_i_ecause_ip;
                    r.interrupt = p.trace_rv_i_interrupt_ip[i];
                    r.tval      = p.trace_rv_i_tval_ip;
                end
                n++;
            end
        end
        return r;
    endfunction

    task automatic model_clear();
        m_q.delete();
        m_idx  = 0;
        m_ovf  = 1'b0;
        m_drop = 16'd0;
    endtask

    // Advance the model by one rising edge using the current inputs.
    task automatic model_update();
        int occ;
        if (trc_clear) begin
            model_clear();
        end else begin
            occ = m_q.size();
            if (occ != 0 && trc_ready) begin
                m_idx++;
                if (m_idx == nrec(m_q[0])) begin
                    void'(m_q.pop_front());
                    m_idx = 0;
                end
            end
            if (trace_pkt.trace_rv_i_valid_ip != 3'b000) begin
                if (occ < DEPTH) m_q.push_back(trace_pkt);
                else begin
                    m_ovf = 1'b1;
                    if (m_drop != 16'hFFFF) m_drop++;
                end
            end
        end
    endtask

    task automatic compare_all();
        trace_rec_t er;
        logic ev;
        ev = (m_q.size() != 0);
        er = ev ? get_rec(m_q[0], m_idx) : '0;
        chk("valid", 128'(trc_valid), 128'(ev));
        chk("rec", 128'(trc_rec), 128'(er));
        chk("overflow", 128'(trc_overflow), 128'(m_ovf));
        chk("drop_cnt", 128'(trc_drop_cnt), 128'(m_drop));
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        compare_all();
    endtask

    function automatic trace_pkt_t rand_pkt(input logic [2:0] vld);
        trace_pkt_t p;
        p.trace_rv_i_valid_ip     = vld;
        p.trace_rv_i_insn_ip      = {$urandom, $urandom, $urandom};
        p.trace_rv_i_address_ip   = {$urandom, $urandom, $urandom};
        p.trace_rv_i_exception_ip = 3'($urandom);
        p.trace_rv_i_ecause_ip    = 5'($urandom);
        p.trace_rv_i_interrupt_ip = 3'($urandom);
        p.trace_rv_i_tval_ip      = $urandom;
        return p;
    endfunction

    task automatic idle(input int n);
        trace_pkt = '0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        trace_rec_t held;
        checks    = 0;
        errors    = 0;
        rst_l     = 1'b0;
        trace_pkt = '0;
        trc_clear = 1'b0;
        trc_ready = 1'b0;
        model_clear();

        // Reset state
        #2;
        compare_all();
        #20;
        rst_l = 1'b1;

        // Single packet, slots 0 and 2
        trc_ready = 1'b1;
        trace_pkt = rand_pkt(3'b101);
        trace_pkt.trace_rv_i_insn_ip[31:0]  = 32'h00000013;
        trace_pkt.trace_rv_i_insn_ip[95:64] = 32'h00100073;
        tick();
        chk("single_s0", 128'(trc_rec.insn), 128'(32'h00000013));
        trace_pkt = '0;
        tick();
        chk("single_s2", 128'({trc_rec.slot, trc_rec.insn}), 128'({2'd2, 32'h00100073}));
        idle(2);

        // Backpressure on a three-slot packet
        trc_ready = 1'b0;
        trace_pkt = rand_pkt(3'b111);
        tick();
        held = trc_rec;
        trace_pkt = '0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold", 128'(trc_rec), 128'(held));
        end
        trc_ready = 1'b1;
        idle(4);

        // Shared ecause/tval, exception only on slot 1
        trace_pkt = rand_pkt(3'b011);
        trace_pkt.trace_rv_i_ecause_ip    = 5'd2;
        trace_pkt.trace_rv_i_tval_ip      = 32'hDEADBEEF;
        trace_pkt.trace_rv_i_exception_ip = 3'b010;
        tick();
        chk("shared_s0", 128'({trc_rec.exception, trc_rec.ecause, trc_rec.tval}),
            128'({1'b0, 5'd2, 32'hDEADBEEF}));
        trace_pkt = '0;
        tick();
        chk("shared_s1", 128'({trc_rec.exception, trc_rec.ecause, trc_rec.tval}),
            128'({1'b1, 5'd2, 32'hDEADBEEF}));
        idle(2);

        // Overflow: six single-slot packets into a four-deep buffer
        trc_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            trace_pkt = rand_pkt(3'b001);
            tick();
        end
        trace_pkt = '0;
        chk("ovf_cnt", 128'(trc_drop_cnt), 128'(16'd2));
        chk("ovf_flag", 128'(trc_overflow), 128'(1'b1));
        trc_ready = 1'b1;
        idle(5);
        chk("ovf_drained", 128'(trc_valid), 128'(1'b0));

        // Clear with two buffered entries and a present packet
        trc_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            trace_pkt = rand_pkt(3'b111);
            tick();
        end
        trc_clear = 1'b1;
        trace_pkt = rand_pkt(3'b001);
        tick();
        trc_clear = 1'b0;
        trace_pkt = '0;
        chk("clr_valid", 128'(trc_valid), 128'(1'b0));
        chk("clr_drop", 128'({trc_overflow, trc_drop_cnt}), 128'(17'd0));
        idle(2);

        // Asynchronous reset mid-drain with three entries buffered
        for (int i = 0; i < 3; i++) begin
            trace_pkt = rand_pkt(3'($urandom_range(1, 7)));
            tick();
        end
        trace_pkt = '0;
        trc_ready = 1'b1;
        tick();
        #3;
        rst_l = 1'b0;
        #1;
        model_clear();
        chk("arst_valid", 128'(trc_valid), 128'(1'b0));
        chk("arst_rec", 128'(trc_rec), 128'(0));
        @(posedge clk);
        #2;
        rst_l = 1'b1;
        idle(4);
        chk("arst_quiet", 128'(trc_valid), 128'(1'b0));

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 9) < 6) trace_pkt = rand_pkt(3'($urandom_range(1, 7)));
            else trace_pkt = rand_pkt(3'b000);
            trc_ready = ($urandom_range(0, 3) != 0);
            trc_clear = ($urandom_range(0, 99) == 0);
            tick();
        end
        trc_clear = 1'b0;
        trc_ready = 1'b1;
        idle(16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
